d5m_stream_gen: RTL
===================

Name: d5m_stream_gen

Overview:
- Synthesizable D5M-style pixel-stream transmitter.
- Produces the FVAL/LVAL/12-bit data timing the capture path receives, filled with deterministic test patterns.
- Replaces the camera header in simulation and in on-board bring-up, so the capture, Bayer-conversion and frame-buffer chain can run without the sensor attached.

Parameters:
- ACT_W, 1280, active pixels per line (>=1)
- ACT_H, 960, active lines per frame (>=1)
- HBLANK, 16, LVAL-low cycles between lines within a frame (>=1)
- VBLANK, 32, FVAL-low cycles between frames (>=1)
- FV_LEAD, 4, FVAL-high/LVAL-low cycles before the first line (>=1)
- FV_TRAIL, 4, FVAL-high/LVAL-low cycles after the last line (>=1)

Ports:
- iCLK  input  1  pixel clock; all logic on rising edge
- iRST  input  1  synchronous, active-high reset
- iSTART  input  1  level; begin streaming when idle
- iEND  input  1  level; stop after the current frame completes
- iPATTERN  input  2  pattern select; latched at frame start
- oD  output  12  pixel data
- oFVAL  output  1  frame valid
- oLVAL  output  1  line valid
- oX  output  16  current active column (0..ACT_W-1), valid while oLVAL=1
- oY  output  16  current active line (0..ACT_H-1), valid while oFVAL=1
- oFrame_Cont  output  32  completed-frame count
- oBUSY  output  1  high whenever state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, stop_pending=0, latched pattern=0. If iRST is high mid-frame, every output is 0 after that edge; no partial-frame completion.
- All outputs are registered and change together on the same edge.
- oD is 0 whenever oLVAL=0.
- States:
  - IDLE: iSTART=1 and iEND=0 -> FV_LEAD; latch iPATTERN; clear stop_pending. iSTART=1 with iEND=1 in the same cycle -> stay IDLE.
  - FV_LEAD: oFVAL=1, oLVAL=0 for FV_LEAD cycles; oY=0. Then LINE.
  - LINE: oFVAL=1, oLVAL=1 for ACT_W cycles; oX counts 0..ACT_W-1. On the last pixel: if oY=ACT_H-1 -> FV_TRAIL, else -> HBLANK.
  - HBLANK: oLVAL=0 for HBLANK cycles; oY increments by 1 on entry to the next LINE; oX=0. Then LINE.
  - FV_TRAIL: oFVAL=1, oLVAL=0 for FV_TRAIL cycles. On exit, oFrame_Cont += 1 (wraps at 2^32). Then: stop_pending=1 -> IDLE (stop_pending cleared), else -> VBLANK.
  - VBLANK: all valids 0 for VBLANK cycles; oY=0. Then FV_LEAD; re-latch iPATTERN; re-sample iEND.
- Stop: iEND=1 in any non-IDLE cycle sets stop_pending. The current frame always finishes intact, and FVAL never drops mid-frame.
- iSTART is ignored while not IDLE.
- Frame period while streaming: FV_LEAD + ACT_H*ACT_W + (ACT_H-1)*HBLANK + FV_TRAIL + VBLANK.
- oFVAL rises exactly 1 cycle after iSTART is sampled in IDLE.
- Pattern value during LINE. Frame-latched pattern p; x=oX, y=oY, f=oFrame_Cont; arithmetic truncated to 12 bits:
  - p=0: x[11:0] (horizontal ramp)
  - p=1: y[11:0] (vertical ramp)
  - p=2: Bayer flat field. Even row: even col 12'h800 (G), odd col 12'hFFF (R). Odd row: even col 12'h000 (B), odd col 12'h800 (G).
  - p=3: (x + y + f[11:0]) mod 4096
- Changing iPATTERN mid-frame has no effect until the next frame start.
- Counters are sized for 16-bit x/y; parameters >65535 are unsupported.

Test Plan:
- Overrides ACT_W=4, ACT_H=2, HBLANK=2, VBLANK=3, FV_LEAD=2, FV_TRAIL=2, iPATTERN=0, pulse iSTART one cycle:
  - oFVAL rises next cycle and stays high 14 cycles, then low 3 cycles; period 17.
  - oLVAL high 4 cycles, low 2, high 4.
  - oD=0,1,2,3 on each line; oY=0 then 1.
- Same config, iPATTERN=3, stream 3 frames:
  - frame 0 line 1 gives oD=1,2,3,4.
  - frame 2 line 0 gives oD=2,3,4,5.
  - oFrame_Cont reads 1,2,3 after each FV_TRAIL exit.
- iEND asserted during line 0 of frame 0:
  - frame completes fully (14 FVAL-high cycles); oFrame_Cont=1; state IDLE; oBUSY=0.
  - no VBLANK/next FV_LEAD.
- iPATTERN=2, ACT_W=4, ACT_H=2:
  - line 0 gives oD=800,FFF,800,FFF (hex).
  - line 1 gives oD=000,800,000,800.
  - iPATTERN changed to 0 mid-frame does not alter the current frame.
- iRST asserted during line 1 LINE state: next edge oFVAL=oLVAL=oD=oX=oY=oFrame_Cont=0, oBUSY=0. After deassert, no output until iSTART.
- iSTART and iEND high in the same IDLE cycle: oFVAL stays 0, oBUSY stays 0. iSTART pulsed mid-frame: timing unchanged versus the golden 17-cycle period.

Source files
------------

// File: rtl/d5m_stream_gen.sv
// D5M-style FVAL/LVAL/12-bit pixel stream generator with deterministic test patterns.
// Stands in for the camera header so the capture chain can run without a sensor.
module d5m_stream_gen #(
    parameter int unsigned ACT_W    = 1280,
    parameter int unsigned ACT_H    = 960,
    parameter int unsigned HBLANK   = 16,
    parameter int unsigned VBLANK   = 32,
    parameter int unsigned FV_LEAD  = 4,
    parameter int unsigned FV_TRAIL = 4
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSTART,
    input  logic        iEND,
    input  logic [1:0]  iPATTERN,
    output logic [11:0] oD,
    output logic        oFVAL,
    output logic        oLVAL,
    output logic [15:0] oX,
    output logic [15:0] oY,
    output logic [31:0] oFrame_Cont,
    output logic        oBUSY
);

    localparam logic [15:0] LastX     = 16'(ACT_W - 1);
    localparam logic [15:0] LastY     = 16'(ACT_H - 1);
    localparam logic [15:0] LastHb    = 16'(HBLANK - 1);
    localparam logic [15:0] LastVb    = 16'(VBLANK - 1);
    localparam logic [15:0] LastLead  = 16'(FV_LEAD - 1);
    localparam logic [15:0] LastTrail = 16'(FV_TRAIL - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLead,
        StLine,
        StHblank,
        StTrail,
        StVblank
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] y_d;
    logic [31:0] frame_d;
    logic [1:0]  pat_q, pat_d;
    logic        stop_q, stop_d;
    logic [11:0] d_d;

    // cnt counts cycles within the current state; in LINE it is the column.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = oY;
        frame_d = oFrame_Cont;
        pat_d   = pat_q;
        stop_d  = stop_q | (iEND && (state_q != StIdle));

        unique case (state_q)
            StIdle: begin
                if (iSTART && !iEND) begin
                    state_d = StLead;
                    cnt_d   = '0;
                    y_d     = '0;
                    pat_d   = iPATTERN;
                    stop_d  = 1'b0;
                end
            end
            StLead: begin
                if (cnt_q == LastLead) begin
                    state_d = StLine;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StLine: begin
                if (cnt_q == LastX) begin
                    cnt_d   = '0;
                    state_d = (oY == LastY) ? StTrail : StHblank;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StHblank: begin
                if (cnt_q == LastHb) begin
                    state_d = StLine;
                    cnt_d   = '0;
                    y_d     = oY + 16'd1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StTrail: begin
                if (cnt_q == LastTrail) begin
                    cnt_d   = '0;
                    y_d     = '0;
                    frame_d = oFrame_Cont + 32'd1;
                    if (stop_d) begin
                        state_d = StIdle;
                        stop_d  = 1'b0;
                    end else begin
                        state_d = StVblank;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StVblank: begin
                if (cnt_q == LastVb) begin
                    state_d = StLead;
                    cnt_d   = '0;
                    pat_d   = iPATTERN;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Pixel value for the upcoming cycle, from next-state column/line/frame.
    always_comb begin
        d_d = '0;
        if (state_d == StLine) begin
            unique case (pat_d)
                2'd0: d_d = cnt_d[11:0];
                2'd1: d_d = y_d[11:0];
                2'd2: begin
                    if (!y_d[0]) d_d = cnt_d[0] ? 12'hFFF : 12'h800;
                    else         d_d = cnt_d[0] ? 12'h800 : 12'h000;
                end
                default: d_d = cnt_d[11:0] + y_d[11:0] + frame_d[11:0];
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            pat_q       <= '0;
            stop_q      <= 1'b0;
            oD          <= '0;
            oFVAL       <= 1'b0;
            oLVAL       <= 1'b0;
            oX          <= '0;
            oY          <= '0;
            oFrame_Cont <= '0;
            oBUSY       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pat_q       <= pat_d;
            stop_q      <= stop_d;
            oD          <= d_d;
            oFVAL       <= (state_d != StIdle) && (state_d != StVblank);
            oLVAL       <= (state_d == StLine);
            oX          <= (state_d == StLine) ? cnt_d : 16'd0;
            oY          <= y_d;
            oFrame_Cont <= frame_d;
            oBUSY       <= (state_d != StIdle);
        end
    end

endmodule
